mem_bus_ctrl: RTL and testbench

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

---
 rtl/mem_map_pkg.sv | 32 +++
 rtl/mem_addr_decode.sv | 43 ++++
 rtl/mem_bus_ctrl.sv | 134 +++++++++++++
 tb/tb_mem_bus_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// Shared address-map constants, FSM state encoding and decode result types
// for the CPU memory bus controller.
package mem_map_pkg;

    localparam logic [7:0] MAP_ROM_LAST  = 8'h7F;
    localparam logic [7:0] MAP_RAM_BASE  = 8'h80;
    localparam int         MAP_RAM_DEPTH = 96;
    localparam logic [7:0] MAP_OUT_BASE  = 8'hE0;
    localparam logic [7:0] MAP_IN_BASE   = 8'hF0;
    localparam int         NUM_PORTS     = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic rom;
        logic ram;
        logic outp;
        logic inp;
        logic none;
    } region_t;

    typedef struct packed {
        region_t    region;
        logic [1:0] port_idx;
        logic       illegal_wr;
    } dec_t;

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational CPU address decoder: region one-hot, port index within the
// port block, and a flag for writes into read-only or unmapped space.
module mem_addr_decode
    import mem_map_pkg::*;
#(
    parameter logic [7:0] RAM_BASE  = MAP_RAM_BASE,
    parameter int         RAM_DEPTH = MAP_RAM_DEPTH,
    parameter logic [7:0] OUT_BASE  = MAP_OUT_BASE,
    parameter logic [7:0] IN_BASE   = MAP_IN_BASE
) (
    input  logic [7:0] addr,
    input  logic       we,
    output dec_t       dec
);

    logic [8:0] ram_end;
    logic [7:0] out_off;
    logic [7:0] in_off;

    // 9-bit compare so a window ending at 0x100 does not wrap
    assign ram_end = {1'b0, RAM_BASE} + 9'(RAM_DEPTH);
    assign out_off = addr - OUT_BASE;
    assign in_off  = addr - IN_BASE;

    always_comb begin
        dec = '0;
        if (addr <= MAP_ROM_LAST) begin
            dec.region.rom = 1'b1;
        end else if ({1'b0, addr} >= {1'b0, RAM_BASE} && {1'b0, addr} < ram_end) begin
            dec.region.ram = 1'b1;
        end else if (addr >= OUT_BASE && out_off < 8'(NUM_PORTS)) begin
            dec.region.outp = 1'b1;
            dec.port_idx    = out_off[1:0];
        end else if (addr >= IN_BASE && in_off < 8'(NUM_PORTS)) begin
            dec.region.inp = 1'b1;
            dec.port_idx   = in_off[1:0];
        end else begin
            dec.region.none = 1'b1;
        end
        dec.illegal_wr = we & (dec.region.rom | dec.region.inp | dec.region.none);
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU memory bus controller: three-cycle IDLE/ACCESS/RESP handshake onto
// program ROM, 96-byte data RAM, four output registers and four input ports.
module mem_bus_ctrl
    import mem_map_pkg::*;
#(
    parameter logic [7:0] RAM_BASE  = MAP_RAM_BASE,
    parameter int         RAM_DEPTH = MAP_RAM_DEPTH,
    parameter logic [7:0] OUT_BASE  = MAP_OUT_BASE,
    parameter logic [7:0] IN_BASE   = MAP_IN_BASE
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       cpu_ack,
    output logic       cpu_err,
    output logic [6:0] rom_address,
    input  logic [7:0] rom_data,
    output logic       ram_write,
    output logic [6:0] ram_address,
    output logic [7:0] ram_data_in,
    input  logic [7:0] ram_data_out,
    input  logic [7:0] port_in_0,
    input  logic [7:0] port_in_1,
    input  logic [7:0] port_in_2,
    input  logic [7:0] port_in_3,
    output logic [7:0] port_out_0,
    output logic [7:0] port_out_1,
    output logic [7:0] port_out_2,
    output logic [7:0] port_out_3
);

    state_t state, state_nxt;

    logic [7:0] lat_addr;
    logic [7:0] lat_wdata;
    logic       lat_we;
    dec_t       dec;
    logic [7:0] rd_mux;

    logic [NUM_PORTS-1:0][7:0] port_in_v;
    logic [NUM_PORTS-1:0][7:0] sync1, sync2;
    logic [NUM_PORTS-1:0][7:0] port_out_q;

    assign port_in_v  = {port_in_3, port_in_2, port_in_1, port_in_0};
    assign port_out_0 = port_out_q[0];
    assign port_out_1 = port_out_q[1];
    assign port_out_2 = port_out_q[2];
    assign port_out_3 = port_out_q[3];

    mem_addr_decode #(
        .RAM_BASE (RAM_BASE),
        .RAM_DEPTH(RAM_DEPTH),
        .OUT_BASE (OUT_BASE),
        .IN_BASE  (IN_BASE)
    ) u_dec (
        .addr(lat_addr),
        .we  (lat_we),
        .dec (dec)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (cpu_req) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Strobes come straight off the state register so a reset aborts them at once
    always_comb begin
        cpu_ack   = (state == ST_RESP);
        ram_write = (state == ST_ACCESS) && lat_we && dec.region.ram;
    end

    assign rom_address = lat_addr[6:0];
    assign ram_address = 7'(lat_addr - RAM_BASE);
    assign ram_data_in = lat_wdata;

    always_comb begin
        rd_mux = 8'h00;
        if (dec.region.rom)       rd_mux = rom_data;
        else if (dec.region.ram)  rd_mux = ram_data_out;
        else if (dec.region.outp) rd_mux = port_out_q[dec.port_idx];
        else if (dec.region.inp)  rd_mux = sync2[dec.port_idx];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= port_in_v;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_addr   <= 8'h00;
            lat_wdata  <= 8'h00;
            lat_we     <= 1'b0;
            cpu_rdata  <= 8'h00;
            cpu_err    <= 1'b0;
            port_out_q <= '0;
        end else begin
            if (state == ST_IDLE && cpu_req) begin
                lat_addr  <= cpu_addr;
                lat_wdata <= cpu_wdata;
                lat_we    <= cpu_we;
            end
            // err is only ever high during RESP
            cpu_err <= 1'b0;
            if (state == ST_ACCESS) begin
                cpu_err <= dec.illegal_wr | dec.region.none;
                if (!lat_we)
                    cpu_rdata <= rd_mux;
                else if (dec.region.outp)
                    port_out_q[dec.port_idx] <= lat_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl with a behavioural ROM/RAM.
module tb_mem_bus_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cpu_req = 1'b0;
    logic       cpu_we = 1'b0;
    logic [7:0] cpu_addr = 8'h00;
    logic [7:0] cpu_wdata = 8'h00;
    logic [7:0] cpu_rdata;
    logic       cpu_ack, cpu_err;
    logic [6:0] rom_address;
    logic [7:0] rom_data;
    logic       ram_write;
    logic [6:0] ram_address;
    logic [7:0] ram_data_in, ram_data_out;
    logic [7:0] port_in_0 = 8'h00, port_in_1 = 8'h00, port_in_2 = 8'h00, port_in_3 = 8'h00;
    logic [7:0] port_out_0, port_out_1, port_out_2, port_out_3;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] mem [0:95];
    logic       pl_en = 1'b0;
    logic [6:0] pl_addr = 7'd0;
    logic [7:0] pl_data = 8'h00;

    // phase captures: a_* during ACCESS, r_* during RESP
    logic       a_rw, a_ack, r_rw, r_ack, r_err;
    logic [6:0] a_ra, a_roa;
    logic [7:0] a_p2, r_p2, r_rdata;
    int         ack_idx [3];
    int         n_ack;

    always #5 clk = ~clk;

    assign rom_data     = ~{1'b0, rom_address};
    assign ram_data_out = (ram_address < 7'd96) ? mem[ram_address] : 8'h00;

    always @(posedge clk) begin
        if (ram_write)  mem[ram_address] <= ram_data_in;
        else if (pl_en) mem[pl_addr] <= pl_data;
    end

    mem_bus_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ack     (cpu_ack),
        .cpu_err     (cpu_err),
        .rom_address (rom_address),
        .rom_data    (rom_data),
        .ram_write   (ram_write),
        .ram_address (ram_address),
        .ram_data_in (ram_data_in),
        .ram_data_out(ram_data_out),
        .port_in_0   (port_in_0),
        .port_in_1   (port_in_1),
        .port_in_2   (port_in_2),
        .port_in_3   (port_in_3),
        .port_out_0  (port_out_0),
        .port_out_1  (port_out_1),
        .port_out_2  (port_out_2),
        .port_out_3  (port_out_3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // One full transaction from IDLE; returns at the RESP-cycle negedge.
    // Inputs are scrambled right after acceptance to prove they were latched.
    task automatic txn(input logic we, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        @(posedge clk);
        #1;
        cpu_req = 1'b0; cpu_we = ~we; cpu_addr = 8'hE9; cpu_wdata = ~d;
        @(negedge clk);
        a_rw = ram_write; a_ra = ram_address; a_roa = rom_address;
        a_ack = cpu_ack; a_p2 = port_out_2;
        @(negedge clk);
        r_rw = ram_write; r_ack = cpu_ack; r_err = cpu_err;
        r_rdata = cpu_rdata; r_p2 = port_out_2;
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_ack", 32'(cpu_ack), 32'd0);
        chk("rst_err", 32'(cpu_err), 32'd0);
        chk("rst_rdata", 32'(cpu_rdata), 32'h00);
        chk("rst_ram_write", 32'(ram_write), 32'd0);
        chk("rst_ports", {port_out_3, port_out_2, port_out_1, port_out_0}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        preload(7'd0, 8'h33);
        preload(7'd95, 8'h9C);
        preload(7'd6, 8'h44);

        // RAM read at window base and top
        txn(1'b0, 8'h80, 8'h00);
        chk("rd80_ram_addr", 32'(a_ra), 32'd0);
        chk("rd80_ack_access", 32'(a_ack), 32'd0);
        chk("rd80_ack", 32'(r_ack), 32'd1);
        chk("rd80_rdata", 32'(r_rdata), 32'h33);
        chk("rd80_err", 32'(r_err), 32'd0);
        txn(1'b0, 8'hDF, 8'h00);
        chk("rdDF_ram_addr", 32'(a_ra), 32'd95);
        chk("rdDF_rdata", 32'(r_rdata), 32'h9C);

        // RAM write then readback
        txn(1'b1, 8'h85, 8'h5A);
        chk("wr85_ram_write_access", 32'(a_rw), 32'd1);
        chk("wr85_ram_addr", 32'(a_ra), 32'd5);
        chk("wr85_ram_write_resp", 32'(r_rw), 32'd0);
        chk("wr85_err", 32'(r_err), 32'd0);
        chk("wr85_mem", 32'(mem[5]), 32'h5A);
        chk("wr85_rdata_held", 32'(r_rdata), 32'h9C);
        txn(1'b0, 8'h85, 8'h00);
        chk("rd85_rdata", 32'(r_rdata), 32'h5A);
        chk("rd85_err", 32'(r_err), 32'd0);

        // ROM read, illegal writes, unmapped read
        txn(1'b0, 8'h10, 8'h00);
        chk("rd10_rom_addr", 32'(a_roa), 32'h10);
        chk("rd10_rdata", 32'(r_rdata), 32'hEF);
        chk("rd10_err", 32'(r_err), 32'd0);
        txn(1'b1, 8'h10, 8'hAA);
        chk("wr10_err", 32'(r_err), 32'd1);
        chk("wr10_ack", 32'(r_ack), 32'd1);
        chk("wr10_ram_write", 32'(a_rw), 32'd0);
        chk("wr10_rdata_held", 32'(r_rdata), 32'hEF);
        txn(1'b1, 8'hE8, 8'hAA);
        chk("wrE8_err", 32'(r_err), 32'd1);
        chk("wrE8_ack", 32'(r_ack), 32'd1);
        chk("wrE8_ram_write", 32'(a_rw), 32'd0);
        chk("wrE8_ports", {port_out_3, port_out_2, port_out_1, port_out_0}, 32'h0);
        txn(1'b0, 8'hE8, 8'h00);
        chk("rdE8_rdata", 32'(r_rdata), 32'h00);
        chk("rdE8_err", 32'(r_err), 32'd1);

        // output port write timing and readback
        txn(1'b1, 8'hE2, 8'hC3);
        chk("wrE2_port_access", 32'(a_p2), 32'h00);
        chk("wrE2_port_resp", 32'(r_p2), 32'hC3);
        chk("wrE2_err", 32'(r_err), 32'd0);
        chk("wrE2_other_ports", {port_out_3, port_out_1, port_out_0}, 32'h0);
        txn(1'b0, 8'hE2, 8'h00);
        chk("rdE2_rdata", 32'(r_rdata), 32'hC3);

        // input port through synchroniser; writes to it are rejected
        @(negedge clk);
        port_in_1 = 8'h7E;
        @(negedge clk);
        @(negedge clk);
        txn(1'b0, 8'hF1, 8'h00);
        chk("rdF1_rdata", 32'(r_rdata), 32'h7E);
        chk("rdF1_err", 32'(r_err), 32'd0);
        txn(1'b1, 8'hF1, 8'h55);
        chk("wrF1_err", 32'(r_err), 32'd1);

        // request held high for 9 edges: accepts at 1,4,7, acks seen after 2,5,8
        @(negedge clk);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h80;
        n_ack = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                if (n_ack < 3) ack_idx[n_ack] = i;
                n_ack++;
            end
            if (i == 9) cpu_req = 1'b0;
        end
        chk("held_ack_count", 32'(n_ack), 32'd3);
        chk("held_ack0", 32'(ack_idx[0]), 32'd2);
        chk("held_ack1", 32'(ack_idx[1]), 32'd5);
        chk("held_ack2", 32'(ack_idx[2]), 32'd8);

        // reset during ACCESS of a RAM write aborts it
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h86; cpu_wdata = 8'h77;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        chk("abort_ram_write_before", 32'(ram_write), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_ram_write", 32'(ram_write), 32'd0);
        chk("abort_ack", 32'(cpu_ack), 32'd0);
        chk("abort_err", 32'(cpu_err), 32'd0);
        chk("abort_rdata", 32'(cpu_rdata), 32'h00);
        chk("abort_ports", {port_out_3, port_out_2, port_out_1, port_out_0}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        n_ack = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (cpu_ack) n_ack++;
        end
        chk("abort_no_ack", 32'(n_ack), 32'd0);
        chk("abort_mem", 32'(mem[6]), 32'h44);
        txn(1'b0, 8'h85, 8'h00);
        chk("post_abort_ack_access", 32'(a_ack), 32'd0);
        chk("post_abort_ack", 32'(r_ack), 32'd1);
        chk("post_abort_rdata", 32'(r_rdata), 32'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
